// File: rtl/minmax_tracker_8bit.sv
// Streaming window max tracker: finds max, first index and tie count over WIN_LEN samples
// using an external 8-bit comparator. Define CMP_ONEHOT_CHECK_EN to add the sticky err output.
module minmax_tracker_8bit #(
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] cmp_b,
  input  logic       cmp_eq,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_max,
  output logic [7:0] out_idx,
  output logic [7:0] out_ties
`ifdef CMP_ONEHOT_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam logic [7:0] LAST = 8'(WIN_LEN - 1);

  typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic [7:0] max;
    logic [7:0] idx;
    logic [7:0] ties;
  } res_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  res_t       res_q, res_d;
  logic       err_q, err_d;
  logic       accept;
  logic       is_gt, is_eq, flags_bad;
  logic [2:0] flags;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // cmp_b comes straight off the register so the external comparator sees no loop
  assign cmp_b    = res_q.max;
  assign out_max  = res_q.max;
  assign out_idx  = res_q.idx;
  assign out_ties = res_q.ties;

  assign flags = {cmp_gt, cmp_eq, cmp_lt};

`ifdef CMP_ONEHOT_CHECK_EN
  // Illegal flag combinations fall back to "less than" so the window still closes
  always_comb begin
    flags_bad = !$onehot(flags);
    is_gt     = flags[2] & ~flags_bad;
    is_eq     = flags[1] & ~flags_bad;
  end
  assign err = err_q;
`else
  always_comb begin
    flags_bad = 1'b0;
    is_gt     = 1'b0;
    is_eq     = 1'b0;
    casez (flags)
      3'b1??:  is_gt = 1'b1;
      3'b01?:  is_eq = 1'b1;
      default: ;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          res_d   = '{max: in_data, idx: 8'd0, ties: 8'd1};
          cnt_d   = 8'd1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (is_gt)
            res_d = '{max: in_data, idx: cnt_q, ties: 8'd1};
          else if (is_eq && res_q.ties != 8'hFF)
            res_d.ties = res_q.ties + 8'd1;
          if (flags_bad)
            err_d = 1'b1;
          if (cnt_q == LAST)
            state_d = HOLD;
        end
      end
      HOLD: begin
        // Result registers are left alone; the next EMPTY accept overwrites them
        if (out_ready) begin
          state_d = EMPTY;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

`ifndef CMP_ONEHOT_CHECK_EN
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_minmax_tracker_8bit.sv
// Bench for minmax_tracker_8bit: directed scenarios plus random traffic against a
// queue-based window model with an ideal comparator in front of the DUT.
module tb_minmax_tracker_8bit;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, cmp_b, out_max, out_idx, out_ties;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic       ovr_en;
  logic [2:0] ovr;
`ifdef CMP_ONEHOT_CHECK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  // Ideal external comparator, with an override to inject illegal flag patterns
  assign cmp_gt = ovr_en ? ovr[2] : (in_data > cmp_b);
  assign cmp_eq = ovr_en ? ovr[1] : (in_data == cmp_b);
  assign cmp_lt = ovr_en ? ovr[0] : (in_data < cmp_b);

  minmax_tracker_8bit #(.WIN_LEN(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmp_b(cmp_b), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_ties(out_ties)
`ifdef CMP_ONEHOT_CHECK_EN
    , .err(err)
`endif
  );

  int n_chk = 0, n_fail = 0;

  bit         model_on;
  byte unsigned win_q[$];
  bit         pending;
  logic [7:0] last_max, e_max, e_idx, e_ties;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q_max();
    logic [7:0] m = 0;
    foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
    return m;
  endfunction

  task automatic model_close();
    int t = 0, first = -1;
    e_max = q_max();
    foreach (win_q[i]) if (win_q[i] == e_max) begin
      t++;
      if (first < 0) first = i;
    end
    e_idx    = 8'(first);
    e_ties   = (t > 255) ? 8'd255 : 8'(t);
    last_max = e_max;
    pending  = 1;
    win_q.delete();
  endtask

  // One clock: drive inputs, compare against the model, advance both
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, output bit acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (model_on) begin
      chk("out_valid", 32'(out_valid), 32'(pending));
      chk("in_ready", 32'(in_ready), 32'(!pending));
      chk("cmp_b", 32'(cmp_b), 32'(win_q.size() != 0 ? q_max() : last_max));
      if (pending) begin
        chk("out_max", 32'(out_max), 32'(e_max));
        chk("out_idx", 32'(out_idx), 32'(e_idx));
        chk("out_ties", 32'(out_ties), 32'(e_ties));
      end
    end
    @(posedge clk); #1;
    if (pending) begin
      if (ordy) pending = 0;
    end else if (v) begin
      win_q.push_back(d);
      if (win_q.size() == W) model_close();
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy);
    bit a;
    cycle(v, d, ordy, a);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; in_data = 8'hEE; out_ready = 0;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    win_q.delete(); pending = 0; last_max = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cmp_b", 32'(cmp_b), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_ties", 32'(out_ties), 0);
`ifdef CMP_ONEHOT_CHECK_EN
    chk("rst_err", 32'(err), 0);
`endif
  endtask

  task automatic chk_res(input string tag, input logic [7:0] m, input logic [7:0] i, input logic [7:0] t);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_max"}, 32'(out_max), 32'(m));
    chk({tag, "_idx"}, 32'(out_idx), 32'(i));
    chk({tag, "_ties"}, 32'(out_ties), 32'(t));
  endtask

  initial begin
    int acc_cnt;
    bit a;
    ovr_en = 0; ovr = 3'b000; model_on = 1;
    in_valid = 0; in_data = 0; out_ready = 0; rst = 0;
    do_reset();

    // Back-to-back window with a repeated maximum
    cyc(1, 3, 0); cyc(1, 9, 0); cyc(1, 5, 0); cyc(1, 9, 0);
    chk_res("win3959", 9, 1, 2);
    // Stall the result for five cycles while a sample is offered
    for (int k = 0; k < 5; k++) begin
      cyc(1, 8'hAA, 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk_res("stall", 9, 1, 2);
    end
    cyc(0, 0, 1);
    chk("release_in_ready", 32'(in_ready), 1);
    chk("release_out_valid", 32'(out_valid), 0);

    // Bubbles between samples
    cyc(1, 200, 1); cyc(0, 0, 1); cyc(1, 10, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 200, 1); cyc(0, 0, 1); cyc(1, 255, 0);
    chk_res("bubbles", 255, 3, 1);
    cyc(0, 0, 1);

    // Reset mid-window discards the partial result
    cyc(1, 50, 0); cyc(1, 60, 0);
    do_reset();
    cyc(1, 7, 0); cyc(1, 7, 0); cyc(1, 7, 0); cyc(1, 7, 0);
    chk_res("sevens", 7, 0, 4);
    cyc(0, 0, 1);

    // Reset while a result is pending
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 4, 0);
    do_reset();

    // Continuous stream: one window every W+1 cycles
    acc_cnt = 0;
    for (int k = 0; k < 5 * (W + 1); k++) begin
      cycle(1, 8'($urandom_range(0, 255)), 1, a);
      if (a) acc_cnt++;
    end
    chk("throughput", 32'(acc_cnt), 32'(5 * W));

    // Random traffic, small data range to provoke ties
    for (int k = 0; k < 600; k++) begin
      logic [7:0] d;
      if ($urandom_range(0, 149) == 0) do_reset();
      d = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      cyc(1'($urandom_range(0, 9) < 7), d, 1'($urandom_range(0, 1)));
    end

    // Illegal comparator flag patterns
    do_reset();
    model_on = 0;
`ifdef CMP_ONEHOT_CHECK_EN
    cyc(1, 4, 0);
    ovr_en = 1; ovr = 3'b110;
    cyc(1, 8, 0);
    ovr_en = 0;
    chk("err_set", 32'(err), 1);
    chk("err_max_kept", 32'(cmp_b), 4);
    cyc(1, 1, 0);
    chk("err_not_closed", 32'(out_valid), 0);
    cyc(1, 2, 0);
    chk_res("err_win", 4, 0, 1);
    chk("err_hold", 32'(err), 1);
    cyc(0, 0, 1);
    chk("err_sticky", 32'(err), 1);
`else
    cyc(1, 5, 0);
    ovr_en = 1; ovr = 3'b011; cyc(1, 2, 0);
    ovr_en = 0;               cyc(1, 1, 0);
    ovr_en = 1; ovr = 3'b000; cyc(1, 0, 0);
    ovr_en = 0;
    chk_res("prio_eq", 5, 0, 2);
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    ovr_en = 1; ovr = 3'b110; cyc(1, 0, 0);
    ovr_en = 0;               cyc(1, 0, 0);
    ovr_en = 1; ovr = 3'b000; cyc(1, 0, 0);
    ovr_en = 0;
    chk_res("prio_gt", 0, 1, 2);
    cyc(0, 0, 1);
`endif
    do_reset();
    model_on = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_tracker_8bit.md
MINMAX_TRACKER_8BIT -- requirements
Module: minmax_tracker_8bit

Interface
REQ-001 SHALL have parameter: WIN_LEN, 4, samples per window (legal 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  sample offered.
REQ-005 SHALL have port: in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-006 SHALL have port: in_data  input  8  sample; wired externally to the 8-bit comparator's A.
REQ-007 SHALL have port: cmp_b  output  8  current max register; wired to the comparator's B.
REQ-008 SHALL have port: cmp_eq, cmp_gt, cmp_lt  input  1 each  comparator result for in_data vs cmp_b, same cycle.
REQ-009 SHALL have port: out_valid  output  1  window result available.
REQ-010 SHALL have port: out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 SHALL have port: out_max  output  8  window maximum.
REQ-012 SHALL have port: out_idx  output  8  0-based index of first occurrence of max in window.
REQ-013 SHALL have port: out_ties  output  8  number of window samples equal to max, saturating at 255.

Function
REQ-014 SHALL implement states EMPTY, ACCUM, HOLD; in_ready=1 in EMPTY/ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-015 SHALL, on accept in EMPTY: max<=in_data, idx<=0, ties<=1, cnt<=1, go ACCUM; cmp flags ignored.
REQ-016 SHALL, on accept in ACCUM with cmp_gt: max<=in_data, idx<=cnt, ties<=1.
REQ-017 SHALL, on accept in ACCUM with cmp_eq: ties<=ties+1 (saturating); max, idx unchanged.
REQ-018 SHALL, on accept in ACCUM with cmp_lt: max, idx, ties unchanged.
REQ-019 SHALL increment cnt on every accept in ACCUM; accept with cnt==WIN_LEN-1 SHALL move to HOLD next cycle.
REQ-020 SHALL hold out_max/out_idx/out_ties (= max/idx/ties registers) stable while in HOLD.
REQ-021 SHALL, in HOLD with out_ready=1, return to EMPTY next cycle; cnt<=0; max register unchanged.
REQ-022 SHALL treat cycles with in_valid=0 as no-ops in EMPTY/ACCUM (bubbles permitted anywhere).
REQ-023 SHALL drive cmp_b directly from the max register (no combinational path from in_data).
REQ-024 SHALL achieve steady-state throughput of one window per WIN_LEN+1 cycles with no stalls.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set state EMPTY, cnt=0, max=0, idx=0, ties=0 (so cmp_b=0, out_*=0, out_valid=0, in_ready=1 next cycle).
REQ-026 SHALL, on rst mid-window or in HOLD, discard the partial/pending result; rst has priority over all events.

Configuration
REQ-027 SHALL, with CMP_ONEHOT_CHECK_EN defined, add output err (1 bit): on accept in ACCUM with {cmp_gt,cmp_eq,cmp_lt} not one-hot, set err sticky until rst; sample counted but treated as cmp_lt.
REQ-028 SHALL, without CMP_ONEHOT_CHECK_EN, omit err and decode flags by priority gt > eq > lt (none set = lt).

Verification
REQ-029 SHALL cover: rst=1 one cycle -> out_valid=0, in_ready=1, cmp_b=0, out_max=out_idx=out_ties=0.
REQ-030 SHALL cover: WIN_LEN=4, samples 3,9,5,9 back-to-back -> cycle after 4th accept out_valid=1, out_max=9, out_idx=1, out_ties=2.
REQ-031 SHALL cover: samples 200,10,200,255 with in_valid bubbles between -> out_max=255, out_idx=3, out_ties=1.
REQ-032 SHALL cover: result pending, out_ready=0 for 5 cycles -> in_ready=0, outputs stable; out_ready=1 -> EMPTY next cycle, in_ready=1.
REQ-033 SHALL cover: rst after 2 accepts, then 7,7,7,7 -> out_max=7, out_idx=0, out_ties=4.
REQ-034 SHALL cover (macro defined): 2nd sample with gt=eq=1 -> err=1 persists, max unchanged, window still closes after 4 accepts.
